regbank_ctrl: RTL and testbench
===============================

Name: regbank_ctrl

Overview:
Command sequencer that drives the write/read port set of the 4 x 32 register bank. It accepts one command at a time over a valid/ready handshake, drives the bank read selects, and captures both read operands. It computes a 32-bit ALU result, writes it back through the bank's synchronous write port, and returns the result and flags on a response handshake. It sits between a host/test driver and the register bank, which has combinational reads and writes on posedge when write=1.

Parameters:
DATA_W, 32, datapath width; equals bank word width
ADDR_W, 2, register select width (4 registers)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  operation code (see Behaviour)
cmd_dr  input  ADDR_W  destination register
cmd_sr1  input  ADDR_W  source register 1
cmd_sr2  input  ADDR_W  source register 2
cmd_imm  input  DATA_W  immediate for LOADI
sr1  output  ADDR_W  bank read select 1
sr2  output  ADDR_W  bank read select 2
rdData1  input  DATA_W  bank read data 1 (combinational from sr1)
rdData2  input  DATA_W  bank read data 2 (combinational from sr2)
dr  output  ADDR_W  bank write select
write  output  1  bank write enable, one-cycle pulse
wrData  output  DATA_W  bank write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumer ready
rsp_data  output  DATA_W  result value
rsp_carry  output  1  carry / no-borrow flag
rsp_zero  output  1  result == 0

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LOADI (result=imm), 6 MOV (result=R[sr1]), 7 READ (result=R[sr1]; no write-back).
- FSM states: IDLE, READ, EXEC, WRITE, RESP. cmd_ready = (state==IDLE). No handshake completes while rst=1.
- IDLE: on cmd_valid&&cmd_ready at edge E0, latch op/dr/imm. Register sr1<=cmd_sr1 and sr2<=cmd_sr2. Go to READ.
- READ: sr1/sr2 are stable. At E1, capture rdData1/rdData2 into operand registers and go to EXEC.
- EXEC: at E2, latch result, carry and zero. Go to WRITE, or to RESP if op=READ.
- WRITE: write=1, dr=latched dr, wrData=result for exactly the cycle between E2 and E3. The bank updates at E3. Go to RESP.
- RESP: rsp_valid=1. rsp_data/rsp_carry/rsp_zero stay stable until rsp_valid&&rsp_ready. On that edge go to IDLE. This gives back-to-back throughput of one command per 5 cycles minimum.
- Latency: write high during cycle 3 after acceptance; rsp_valid high from E3 (E2 for READ).
- Arithmetic:
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum; result wraps modulo 2^DATA_W.
  - SUB: result = a-b mod 2^DATA_W; carry = 1 when a >= b unsigned (no borrow).
  - AND/OR/XOR/LOADI/MOV/READ: carry = 0.
  - zero = (result == 0) for all ops.
- sr1/sr2 hold their last value outside READ. dr/wrData hold their values, but only write qualifies them.
- Hazards: commands are strictly serialised and the write completes before RESP, so a following command always reads the updated register. dr==sr1 within one command reads the old value.
- Reset (async, any state):
  - state=IDLE; write=0 immediately, so an in-flight write-back is dropped and the bank is unchanged.
  - rsp_valid=0; sr1=sr2=dr=0; wrData=0; rsp_data=0; rsp_carry=0; rsp_zero=0.
  - cmd_ready=1 from the first edge after rst deasserts.
- Undefined opcodes: none, since all 8 codes are defined.

Decomposition:
- Shared package regbank_pkg: opcode localparams OP_ADD..OP_READ, FSM state encoding, DATA_W/ADDR_W defaults.
- One combinational sub-module regbank_alu (a, b, imm, op -> result, carry, zero). The FSM and handshakes live in regbank_ctrl.

Test Plan:
- Bench pairs the controller with the 4 x 32 bank model.
- LOADI dr=1 imm=0x00000005, then LOADI dr=2 imm=0x00000003 -> each asserts write for exactly 1 cycle with dr=1/wrData=5, then dr=2/wrData=3; rsp_data=5, then 3.
- ADD dr=3 sr1=1 sr2=2 -> write in cycle 3 after acceptance; R3=0x00000008; rsp_data=8, carry=0, zero=0.
- LOADI R0=0xFFFFFFFF, LOADI R1=1, ADD dr=2 sr1=0 sr2=1 -> R2=0, rsp_carry=1, rsp_zero=1.
- SUB sr1=R(3) sr2=R(5) -> 0xFFFFFFFE, carry=0; swapped operands -> 0x00000002, carry=1.
- READ sr1=3 (R3=8) with rsp_ready held low 5 cycles -> write never asserted; rsp_valid and rsp_data=8 stable, cmd_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Assert rst mid-WRITE of LOADI dr=1 imm=0xA5A5A5A5 -> write drops with rst before the edge; R1 unchanged; outputs at reset values; cmd_ready=1 after release.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank command sequencer: opcodes, FSM encoding, widths.
package regbank_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 2;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_LOADI = 3'd5;
  localparam logic [2:0] OP_MOV   = 3'd6;
  localparam logic [2:0] OP_READ  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;
endpackage

// File: rtl/regbank_alu.sv
// Combinational ALU: result, carry/no-borrow and zero flag for every opcode.
module regbank_alu
  import regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:   begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];   end
      // borrow out of the extended subtract is the inverse of a >= b
      OP_SUB:   begin result = diff[DATA_W-1:0]; carry = ~diff[DATA_W]; end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_LOADI: result = imm;
      OP_MOV:   result = a;
      OP_READ:  result = a;
      default:  result = '0;
    endcase
    zero = (result == '0);
  end
endmodule

// File: rtl/regbank_ctrl.sv
// Command sequencer for the 4 x 32 register bank: select, capture, compute, write back, respond.
module regbank_ctrl
  import regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dr,
  input  logic [ADDR_W-1:0] cmd_sr1,
  input  logic [ADDR_W-1:0] cmd_sr2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  output logic [ADDR_W-1:0] dr,
  output logic              write,
  output logic [DATA_W-1:0] wrData,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero
);
  state_t            state, state_d;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] imm_q, opa, opb, res_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, alu_zero, carry_q, zero_q;
  logic              accept;

  // write and rsp_valid decode straight from state so reset kills them immediately
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign write     = (state == ST_WRITE);
  assign rsp_valid = (state == ST_RESP);
  assign wrData    = res_q;
  assign rsp_data  = res_q;
  assign rsp_carry = carry_q;
  assign rsp_zero  = zero_q;

  regbank_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (opa),
    .b      (opb),
    .imm    (imm_q),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = (op_q == OP_READ) ? ST_RESP : ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_ADD;
      imm_q   <= '0;
      dr      <= '0;
      sr1     <= '0;
      sr2     <= '0;
      opa     <= '0;
      opb     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        imm_q <= cmd_imm;
        dr    <= cmd_dr;
        sr1   <= cmd_sr1;
        sr2   <= cmd_sr2;
      end
      if (state == ST_READ) begin
        opa <= rdData1;
        opb <= rdData2;
      end
      if (state == ST_EXEC) begin
        res_q   <= alu_res;
        carry_q <= alu_carry;
        zero_q  <= alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_regbank_ctrl.sv
// Bench: regbank_ctrl paired with a 4 x 32 bank model; vector table plus scoreboard of responses.
module tb_regbank_ctrl;
  import regbank_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [1:0]  cmd_dr = '0, cmd_sr1 = '0, cmd_sr2 = '0;
  logic [31:0] cmd_imm = '0;
  logic [1:0]  sr1, sr2, dr;
  logic [31:0] rdData1, rdData2, wrData, rsp_data;
  logic        write, rsp_valid, rsp_carry, rsp_zero;
  logic        rsp_ready = 1'b0;

  logic [31:0] bank [4];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  dr;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] imm;
    logic [31:0] d;
    logic        c;
    logic        z;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic        z;
    logic        wr;
    logic [1:0]  dr;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) bank[i] = '0;
  end
  always @(posedge clk) if (write) bank[dr] <= wrData;
  assign rdData1 = bank[sr1];
  assign rdData2 = bank[sr2];

  regbank_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dr(cmd_dr), .cmd_sr1(cmd_sr1), .cmd_sr2(cmd_sr2), .cmd_imm(cmd_imm),
    .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2),
    .dr(dr), .write(write), .wrData(wrData),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t t);
    exp_t e;
    int   nwr, k;
    bit   got;
    e.d = t.d; e.c = t.c; e.z = t.z; e.wr = (t.op != OP_READ); e.dr = t.dr;
    sb.push_back(e);
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = t.op; cmd_dr = t.dr;
    cmd_sr1 = t.s1; cmd_sr2 = t.s2; cmd_imm = t.imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    nwr = 0; got = 0; k = 0;
    while (!got && k < 12) begin
      @(negedge clk);
      k++;
      if (write) begin
        nwr++;
        chk("write_cycle", k, 3);
        chk("write_dr", {30'b0, dr}, {30'b0, sb[0].dr});
        chk("write_data", wrData, sb[0].d);
      end
      if (rsp_valid) begin
        got = 1;
        chk("rsp_latency", k, e.wr ? 4 : 3);
      end
    end
    if (!got) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    for (int h = 0; h < t.hold; h++) begin
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, sb[0].d);
      chk("hold_ready", {31'b0, cmd_ready}, 32'd0);
      chk("hold_write", {31'b0, write}, 32'd0);
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("rsp_data", rsp_data, e.d);
    chk("rsp_carry", {31'b0, rsp_carry}, {31'b0, e.c});
    chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.z});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("write_count", nwr, e.wr ? 1 : 0);
    chk("idle_after_rsp", {30'b0, cmd_ready, rsp_valid}, 32'd2);
    if (e.wr) chk("bank_update", bank[e.dr], e.d);
  endtask

  initial begin
    vec_t v [$];
    v.push_back('{OP_LOADI, 2'd1, 2'd0, 2'd0, 32'h5,        32'h5,        1'b0, 1'b0, 0});
    v.push_back('{OP_LOADI, 2'd2, 2'd0, 2'd0, 32'h3,        32'h3,        1'b0, 1'b0, 0});
    v.push_back('{OP_ADD,   2'd3, 2'd1, 2'd2, 32'h0,        32'h8,        1'b0, 1'b0, 0});
    v.push_back('{OP_LOADI, 2'd0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0});
    v.push_back('{OP_LOADI, 2'd1, 2'd0, 2'd0, 32'h1,        32'h1,        1'b0, 1'b0, 0});
    v.push_back('{OP_ADD,   2'd2, 2'd0, 2'd1, 32'h0,        32'h0,        1'b1, 1'b1, 0});
    v.push_back('{OP_LOADI, 2'd1, 2'd0, 2'd0, 32'h3,        32'h3,        1'b0, 1'b0, 0});
    v.push_back('{OP_LOADI, 2'd2, 2'd0, 2'd0, 32'h5,        32'h5,        1'b0, 1'b0, 0});
    v.push_back('{OP_SUB,   2'd0, 2'd1, 2'd2, 32'h0,        32'hFFFFFFFE, 1'b0, 1'b0, 0});
    v.push_back('{OP_SUB,   2'd0, 2'd2, 2'd1, 32'h0,        32'h2,        1'b1, 1'b0, 0});
    v.push_back('{OP_SUB,   2'd0, 2'd1, 2'd1, 32'h0,        32'h0,        1'b1, 1'b1, 0});
    v.push_back('{OP_AND,   2'd0, 2'd1, 2'd2, 32'h0,        32'h1,        1'b0, 1'b0, 0});
    v.push_back('{OP_OR,    2'd0, 2'd1, 2'd2, 32'h0,        32'h7,        1'b0, 1'b0, 1});
    v.push_back('{OP_XOR,   2'd0, 2'd1, 2'd2, 32'h0,        32'h6,        1'b0, 1'b0, 0});
    v.push_back('{OP_XOR,   2'd0, 2'd1, 2'd1, 32'h0,        32'h0,        1'b0, 1'b1, 0});
    v.push_back('{OP_MOV,   2'd3, 2'd2, 2'd0, 32'h0,        32'h5,        1'b0, 1'b0, 0});
    v.push_back('{OP_LOADI, 2'd3, 2'd0, 2'd0, 32'h8,        32'h8,        1'b0, 1'b0, 0});
    v.push_back('{OP_READ,  2'd0, 2'd3, 2'd0, 32'h0,        32'h8,        1'b0, 1'b0, 5});
    v.push_back('{OP_ADD,   2'd1, 2'd1, 2'd2, 32'h0,        32'h8,        1'b0, 1'b0, 2});

    @(negedge clk);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_outs", {24'b0, sr1, sr2, dr, rsp_carry, rsp_zero}, 32'd0);
    chk("rst_data", rsp_data | wrData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < v.size(); i++) run_vec(v[i]);
    chk("read_kept_r0", bank[0], 32'h0);

    // reset asserted while the LOADI write-back is on the bus
    cmd_valid = 1'b1; cmd_op = OP_LOADI; cmd_dr = 2'd1; cmd_imm = 32'hA5A5A5A5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_write", {31'b0, write}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_write", {31'b0, write}, 32'd0);
    chk("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mid_outs", {24'b0, sr1, sr2, dr, rsp_carry, rsp_zero}, 32'd0);
    chk("rst_mid_data", rsp_data | wrData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst_r1", bank[1], 32'h8);
    run_vec('{OP_ADD, 2'd0, 2'd1, 2'd1, 32'h0, 32'h10, 1'b0, 1'b0, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
